uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage that consumes the frame stream produced by `uart_transmitter` on `serial_output_rx`. Frame: start (0), 8 data bits MSB first, even parity bit, stop (1). The block synchronizes the line, detects the start bit, samples each bit mid-period, checks parity and stop, and presents the byte with a one-cycle valid pulse and error flags.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit period; must be ≥ 4.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `serial_input_rx`  in  1  asynchronous serial line; idles high.
- `data`  out  8  last received byte (`uint8_t`); holds until the next frame completes.
- `data_valid`  out  1  one-cycle pulse when `data` and the error flags update.
- `parity_error`  out  1  received parity ≠ `^data`; updates with `data_valid`.
- `framing_error`  out  1  stop bit sampled 0; updates with `data_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Two-flop synchronizer on `serial_input_rx`; all FSM decisions use the synchronized line `rx_s`.
- States:
  - IDLE: on `rx_s`==0, clear the timer and go to START.
  - START: at half-bit H = floor(CLKS_PER_BIT/2), sample. 1 → false start → IDLE, no outputs change. 0 → DATA.
  - DATA: sample every CLKS_PER_BIT. Shift left, new bit into LSB. After 8 bits → PARITY.
  - PARITY: sample; store `par_err = sample ^ (^shift)`.
  - STOP: sample. Load `data`, `parity_error`, `framing_error` (= ~sample), pulse `data_valid`.
    - Stop = 1 → IDLE.
    - Stop = 0 → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then IDLE. Prevents a held-low line (break) from retriggering.
- Bit period timer: `$clog2(CLKS_PER_BIT)` bits, wraps at CLKS_PER_BIT-1. Bit counter: 4 bits, reset on START exit.
- Even parity: a correct frame satisfies data XOR parity bit = 0.
- `reset` asserted at any time (mid-frame included): FSM → IDLE, counters and shift register cleared, all outputs 0.

## Timing
- Reset values: `data`=8'h00, `data_valid`=0, `parity_error`=0, `framing_error`=0, `busy`=0.
- Let cycle 0 be the first cycle IDLE sees `rx_s`==0. Sample k (k=0 start … 8 data … 9 parity, 10 stop) is taken at cycle H + k·CLKS_PER_BIT.
- `data_valid` and the updated outputs appear in the cycle after sample 10. The FSM is in IDLE (or WAIT_HIGH) in that same cycle, so back-to-back frames with no idle gap are received.
- The pin-to-`rx_s` delay is 2 cycles.
- `busy` rises in cycle 1 and falls in the cycle IDLE is re-entered.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit is decided by a 2-of-3 majority of `rx_s` at offsets H-1, H, H+1. The decision is made at H+1, so every sample point and `data_valid` shift one cycle later. The start-bit qualification uses the majority too.
- Not defined: a single sample at offset H, with the timing given above.

## Structure
- Package `DataTypes` gains:
  - `uart_rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - `UART_DATA_BITS` = 8.
  - `UART_RX_STOP_IDX` = 10.
  - Reuses the existing `bit_t` and `uint8_t`.
- Sub-module `uart_rx_sync`: two-flop synchronizer plus, under `UART_RX_MAJORITY_EN`, the 3-tap history and majority vote. Outputs `rx_s` and `rx_vote`.
- FSM, timer, bit counter and shift register live in `uart_receiver`.

## Test plan
Bench uses CLKS_PER_BIT=16.
- Frame 0xA5, parity 0, stop 1 → one `data_valid` pulse, `data`=0xA5, both errors 0, at cycle H+160+1 from the start edge (plus 2 synchronizer cycles).
- Frame 0x01 with parity 0 (correct parity is 1) → `data`=0x01, `parity_error`=1, `framing_error`=0.
- Frame 0x7E with stop 0, then line held low for 64 cycles → `framing_error`=1 and a single `data_valid`. No further pulse until the line returns high and a new frame arrives.
- Low glitch of 4 cycles on an idle line → `busy` pulses, returns to IDLE after sample 0, no `data_valid`. A 1-cycle glitch at mid-data-bit is rejected only with `UART_RX_MAJORITY_EN`.
- Back-to-back frames 0x3C then 0xC3, no idle gap → two pulses exactly 176 cycles apart with correct data.
- `reset` asserted during data bit 4 → all outputs 0 immediately. The next full frame, 0x5A, is received correctly.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path.
// No configuration macros; UART_RX_MAJORITY_EN is consumed by uart_rx_sync and uart_receiver.
package DataTypes;

  typedef logic       bit_t;
  typedef logic [7:0] uint8_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_RX_STOP_IDX = 10;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop line synchronizer; with UART_RX_MAJORITY_EN defined it also keeps a
// 3-tap history of rx_s and votes 2-of-3, otherwise rx_vote simply follows rx_s.
module uart_rx_sync
  import DataTypes::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s,
  output logic rx_vote
);

  bit_t meta;

  // Flops come out of reset at the idle (high) line level so no false start is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx_in;
      rx_s <= meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  bit_t hist_1;
  bit_t hist_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_1 <= 1'b1;
      hist_2 <= 1'b1;
    end else begin
      hist_1 <= rx_s;
      hist_2 <= hist_1;
    end
  end

  assign rx_vote = (rx_s & hist_1) | (rx_s & hist_2) | (hist_1 & hist_2);
`else
  assign rx_vote = rx_s;
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receive FSM: start/8 data (MSB first)/even parity/stop, one-cycle data_valid.
// UART_RX_MAJORITY_EN selects 2-of-3 bit voting, shifting every sample point one cycle later.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | timing to mid start bit, qualifying it
// DATA      | sampling the 8 data bits
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, publishing the byte
// WAIT_HIGH | stop bit was low; wait for the line to release
module uart_receiver
  import DataTypes::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_input_rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  // Timer is cleared on IDLE exit, so cycle c of the frame sees timer == c-1.
  localparam logic [TW-1:0] START_TC = TW'(HALF - 1 + LAG);
  localparam logic [TW-1:0] BIT_TC   = TW'(CLKS_PER_BIT - 1);

  uart_rx_state_t state;
  logic [TW-1:0]  timer;
  logic [3:0]     bit_cnt;
  uint8_t         shift;
  bit_t           par_err;
  bit_t           rx_s;
  bit_t           rx_vote;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx_in   (serial_input_rx),
    .rx_s    (rx_s),
    .rx_vote (rx_vote)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      par_err       <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      timer      <= (timer == BIT_TC) ? '0 : timer + 1'b1;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == START_TC) begin
            timer   <= '0;
            bit_cnt <= '0;
            if (rx_vote) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (timer == BIT_TC) begin
            shift   <= {shift[6:0], rx_vote};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(UART_DATA_BITS - 1)) state <= PARITY;
          end
        end
        PARITY: begin
          if (timer == BIT_TC) begin
            par_err <= rx_vote ^ (^shift);
            bit_cnt <= bit_cnt + 1'b1;
            state   <= STOP;
          end
        end
        STOP: begin
          if (timer == BIT_TC) begin
            data          <= shift;
            parity_error  <= par_err;
            framing_error <= ~rx_vote;
            data_valid    <= 1'b1;
            if (rx_vote) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLKS_PER_BIT=16; honours UART_RX_MAJORITY_EN.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Pin edge to data_valid: 2 sync cycles + 1 IDLE-detect cycle + H + 10 bits.
  localparam int LAT = 2 + 1 + H + 10 * CPB + MAJ;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_input_rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         np = 0;
  int         pcyc  [16];
  logic [7:0] pdata [16];
  logic       pperr [16];
  logic       pferr [16];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .reset           (reset),
    .serial_input_rx (serial_input_rx),
    .data            (data),
    .data_valid      (data_valid),
    .parity_error    (parity_error),
    .framing_error   (framing_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid && np < 16) begin
      pcyc[np]  = cyc;
      pdata[np] = data;
      pperr[np] = parity_error;
      pferr[np] = framing_error;
      np++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      serial_input_rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s, input int glitch);
    logic v;
    int   k;
    for (int i = 0; i < 11 * CPB; i++) begin
      k = i / CPB;
      if (k == 0)      v = 1'b0;
      else if (k <= 8) v = d[8 - k];
      else if (k == 9) v = p;
      else             v = s;
      if (i == glitch) v = 1'b0;
      serial_input_rx = v;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         hold;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs[5];
  int   n0;
  int   st;

  initial begin
    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, hold: 0,  ed: 8'hA5, ep: 1'b0, ef: 1'b0};
    vecs[1] = '{d: 8'h01, p: 1'b0, s: 1'b1, hold: 0,  ed: 8'h01, ep: 1'b1, ef: 1'b0};
    vecs[2] = '{d: 8'h7E, p: 1'b0, s: 1'b0, hold: 64, ed: 8'h7E, ep: 1'b0, ef: 1'b1};
    vecs[3] = '{d: 8'h00, p: 1'b1, s: 1'b1, hold: 0,  ed: 8'h00, ep: 1'b1, ef: 1'b0};
    vecs[4] = '{d: 8'hC7, p: 1'b1, s: 1'b1, hold: 0,  ed: 8'hC7, ep: 1'b0, ef: 1'b0};

    #1;
    chk("rst_data", data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_perr", parity_error, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(10, 1'b1);

    for (int v = 0; v < 5; v++) begin
      n0 = np;
      st = cyc;
      drive_frame(vecs[v].d, vecs[v].p, vecs[v].s, -1);
      if (vecs[v].hold > 0) begin
        idle(vecs[v].hold, 1'b0);
        chk("hold_busy", busy, 1);
        chk("hold_single_pulse", np - n0, 1);
      end
      idle(24, 1'b1);
      chk("vec_pulses", np - n0, 1);
      chk("vec_data", pdata[n0], vecs[v].ed);
      chk("vec_perr", pperr[n0], vecs[v].ep);
      chk("vec_ferr", pferr[n0], vecs[v].ef);
      chk("vec_latency", pcyc[n0] - st, LAT);
      chk("vec_idle_busy", busy, 0);
    end

    // Short low glitch on an idle line must be discarded at the start-bit sample.
    n0 = np;
    idle(4, 1'b0);
    idle(1, 1'b1);
    chk("glitch_busy_up", busy, 1);
    idle(30, 1'b1);
    chk("glitch_busy_down", busy, 0);
    chk("glitch_no_pulse", np - n0, 0);

    // One-cycle low glitch exactly at the centre of the 4th data bit (bit 4 of 0xFF).
    n0 = np;
    drive_frame(8'hFF, 1'b0, 1'b1, 4 * CPB + H);
    idle(24, 1'b1);
    chk("midglitch_pulses", np - n0, 1);
    chk("midglitch_data", pdata[n0], (MAJ == 1) ? 8'hFF : 8'hEF);
    chk("midglitch_perr", pperr[n0], (MAJ == 1) ? 0 : 1);

    // Back-to-back frames with no idle gap.
    n0 = np;
    drive_frame(8'h3C, 1'b0, 1'b1, -1);
    drive_frame(8'hC3, 1'b0, 1'b1, -1);
    idle(24, 1'b1);
    chk("b2b_pulses", np - n0, 2);
    chk("b2b_data0", pdata[n0], 8'h3C);
    chk("b2b_data1", pdata[n0 + 1], 8'hC3);
    chk("b2b_spacing", pcyc[n0 + 1] - pcyc[n0], 11 * CPB);
    chk("b2b_errs", {pperr[n0], pferr[n0], pperr[n0 + 1], pferr[n0 + 1]}, 0);

    // Reset in the middle of data bit 4 of an all-zero frame.
    n0 = np;
    idle(5 * CPB + H, 1'b0);
    chk("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_data", data, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_perr", parity_error, 0);
    chk("mid_rst_ferr", framing_error, 0);
    chk("mid_rst_busy", busy, 0);
    serial_input_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(20, 1'b1);
    chk("aborted_no_pulse", np - n0, 0);
    st = cyc;
    drive_frame(8'h5A, 1'b0, 1'b1, -1);
    idle(24, 1'b1);
    chk("post_rst_pulses", np - n0, 1);
    chk("post_rst_data", pdata[n0], 8'h5A);
    chk("post_rst_errs", {pperr[n0], pferr[n0]}, 0);
    chk("post_rst_latency", pcyc[n0] - st, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
